// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source FIFOs for EXE and MEM results, fixed EXE priority with
// a MEM starvation counter, and a single registered broadcast per cycle.
module cdb_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       flush,
  input  logic                       exe_valid,
  input  logic [5:0]                 exe_map,
  input  logic [4:0]                 exe_reg,
  input  logic [31:0]                exe_val,
  input  logic [31:0]                exe_instr_num,
  input  logic                       mem_valid,
  input  logic [5:0]                 mem_map,
  input  logic [4:0]                 mem_reg,
  input  logic [31:0]                mem_val,
  input  logic [31:0]                mem_instr_num,
  output logic                       exe_full,
  output logic                       mem_full,
  output logic [$clog2(DEPTH):0]     exe_count,
  output logic [$clog2(DEPTH):0]     mem_count,
  output logic                       cdb_flag,
  output logic [5:0]                 cdb_map,
  output logic [4:0]                 cdb_reg,
  output logic [31:0]                cdb_val,
  output logic [31:0]                cdb_instr_num,
  output logic                       cdb_src,
  output logic                       overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int unsigned EW = 6 + 5 + 32 + 32;

  // Index 0 is EXE, index 1 is MEM throughout.
  logic [EW-1:0] fifo_q [2][DEPTH];
  logic [PW-1:0] wr_q [2];
  logic [PW-1:0] rd_q [2];
  logic [CW-1:0] cnt_q [2];
  logic [WW-1:0] wait_q;
  logic          ovf_q;
  logic          cdb_flag_q;
  logic          cdb_src_q;
  logic [EW-1:0] cdb_ent_q;

  logic [EW-1:0] in_ent [2];
  logic [EW-1:0] head [2];
  logic [1:0]    in_vld, full, acc, pend, win, push, pop;
  logic          mem_win;

  always_comb begin
    in_ent[0] = {exe_map, exe_reg, exe_val, exe_instr_num};
    in_ent[1] = {mem_map, mem_reg, mem_val, mem_instr_num};
    in_vld    = {mem_valid, exe_valid};
    for (int s = 0; s < 2; s++) begin
      full[s] = (cnt_q[s] == CW'(DEPTH));
      acc[s]  = in_vld[s] && !full[s];
      pend[s] = (cnt_q[s] != '0) || acc[s];
      // An empty FIFO lets the accepted input bypass straight to the bus.
      head[s] = (cnt_q[s] != '0) ? fifo_q[s][rd_q[s]] : in_ent[s];
    end
    mem_win = pend[1] && (!pend[0] || (wait_q == WW'(MAX_WAIT)));
    win     = {mem_win, pend[0] && !mem_win};
    for (int s = 0; s < 2; s++) begin
      push[s] = acc[s] && !(win[s] && (cnt_q[s] == '0));
      pop[s]  = win[s] && (cnt_q[s] != '0);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          fifo_q[s][i] <= '0;
        end
        wr_q[s]  <= '0;
        rd_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
      wait_q     <= '0;
      ovf_q      <= 1'b0;
      cdb_flag_q <= 1'b0;
      cdb_src_q  <= 1'b0;
      cdb_ent_q  <= '0;
    end else if (flush) begin
      for (int s = 0; s < 2; s++) begin
        wr_q[s]  <= '0;
        rd_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
      wait_q     <= '0;
      cdb_flag_q <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          fifo_q[s][wr_q[s]] <= in_ent[s];
          wr_q[s]            <= wr_q[s] + 1'b1;
        end
        if (pop[s]) begin
          rd_q[s] <= rd_q[s] + 1'b1;
        end
        cnt_q[s] <= cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
        if (in_vld[s] && full[s]) begin
          ovf_q <= 1'b1;
        end
      end
      if (pend[1] && !win[1]) begin
        if (wait_q != WW'(MAX_WAIT)) begin
          wait_q <= wait_q + 1'b1;
        end
      end else begin
        wait_q <= '0;
      end
      if (win != 2'b00) begin
        cdb_flag_q <= 1'b1;
        cdb_src_q  <= win[1];
        cdb_ent_q  <= win[1] ? head[1] : head[0];
      end else begin
        cdb_flag_q <= 1'b0;
      end
    end
  end

  assign exe_full      = full[0];
  assign mem_full      = full[1];
  assign exe_count     = cnt_q[0];
  assign mem_count     = cnt_q[1];
  assign overflow      = ovf_q;
  assign cdb_flag      = cdb_flag_q;
  assign cdb_src       = cdb_src_q;
  assign cdb_map       = cdb_ent_q[74:69];
  assign cdb_reg       = cdb_ent_q[68:64];
  assign cdb_val       = cdb_ent_q[63:32];
  assign cdb_instr_num = cdb_ent_q[31:0];

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: queue-based reference model checked every cycle, plus
// hand-computed literal expectations at the key points of each scenario.
module tb_cdb_arbiter;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAX_WAIT = 3;

  logic        CLK, RESET, flush;
  logic        exe_valid, mem_valid;
  logic [5:0]  exe_map, mem_map;
  logic [4:0]  exe_reg, mem_reg;
  logic [31:0] exe_val, mem_val, exe_instr_num, mem_instr_num;
  logic        exe_full, mem_full;
  logic [2:0]  exe_count, mem_count;
  logic        cdb_flag, cdb_src, overflow;
  logic [5:0]  cdb_map;
  logic [4:0]  cdb_reg;
  logic [31:0] cdb_val, cdb_instr_num;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .RESET(RESET), .flush(flush),
    .exe_valid(exe_valid), .exe_map(exe_map), .exe_reg(exe_reg), .exe_val(exe_val),
    .exe_instr_num(exe_instr_num),
    .mem_valid(mem_valid), .mem_map(mem_map), .mem_reg(mem_reg), .mem_val(mem_val),
    .mem_instr_num(mem_instr_num),
    .exe_full(exe_full), .mem_full(mem_full), .exe_count(exe_count), .mem_count(mem_count),
    .cdb_flag(cdb_flag), .cdb_map(cdb_map), .cdb_reg(cdb_reg), .cdb_val(cdb_val),
    .cdb_instr_num(cdb_instr_num), .cdb_src(cdb_src), .overflow(overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per source; an accepted input simply joins the back of its
  // queue, and the winner takes the front.
  typedef logic [74:0] ent_t;
  ent_t eq[$];
  ent_t mq[$];
  int   mw;
  logic m_flag, m_src, m_ovf;
  ent_t m_ent;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      eq.delete();
      mq.delete();
      mw = 0;
      m_flag = 1'b0;
      m_src = 1'b0;
      m_ovf = 1'b0;
      m_ent = '0;
    end else if (flush) begin
      eq.delete();
      mq.delete();
      mw = 0;
      m_flag = 1'b0;
    end else begin
      bit ep, mp, mwin;
      if (exe_valid) begin
        if (eq.size() < DEPTH) eq.push_back({exe_map, exe_reg, exe_val, exe_instr_num});
        else m_ovf = 1'b1;
      end
      if (mem_valid) begin
        if (mq.size() < DEPTH) mq.push_back({mem_map, mem_reg, mem_val, mem_instr_num});
        else m_ovf = 1'b1;
      end
      ep = eq.size() > 0;
      mp = mq.size() > 0;
      mwin = mp && (!ep || mw == MAX_WAIT);
      if (mwin) begin
        m_ent = mq.pop_front();
        m_src = 1'b1;
        m_flag = 1'b1;
        mw = 0;
      end else if (ep) begin
        m_ent = eq.pop_front();
        m_src = 1'b0;
        m_flag = 1'b1;
        mw = mp ? mw + 1 : 0;
      end else begin
        m_flag = 1'b0;
        mw = 0;
      end
    end
  end

  always @(negedge CLK) begin
    chk("m_flag", 80'(cdb_flag), 80'(m_flag));
    chk("m_fields", 80'({cdb_map, cdb_reg, cdb_val, cdb_instr_num}), 80'(m_ent));
    chk("m_src", 80'(cdb_src), 80'(m_src));
    chk("m_exe_count", 80'(exe_count), 80'(eq.size()));
    chk("m_mem_count", 80'(mem_count), 80'(mq.size()));
    chk("m_exe_full", 80'(exe_full), 80'(eq.size() == DEPTH));
    chk("m_mem_full", 80'(mem_full), 80'(mq.size() == DEPTH));
    chk("m_overflow", 80'(overflow), 80'(m_ovf));
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic set_exe(input logic v, input int m, input int n);
    exe_valid = v;
    exe_map = 6'(m);
    exe_reg = 5'(m + 1);
    exe_val = 32'(n * 3 + 7);
    exe_instr_num = 32'(n);
  endtask

  task automatic set_mem(input logic v, input int m, input int n);
    mem_valid = v;
    mem_map = 6'(m);
    mem_reg = 5'(m + 2);
    mem_val = 32'(n * 5 + 1);
    mem_instr_num = 32'(n);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_flag"}, 80'(cdb_flag), 80'(0));
    chk({nm, "_fields"}, 80'({cdb_map, cdb_reg, cdb_val, cdb_instr_num, cdb_src}), 80'(0));
    chk({nm, "_counts"}, 80'({exe_count, mem_count}), 80'(0));
    chk({nm, "_full"}, 80'({exe_full, mem_full}), 80'(0));
    chk({nm, "_ovf"}, 80'(overflow), 80'(0));
  endtask

  initial begin
    RESET = 1'b0;
    flush = 1'b0;
    set_exe(1'b0, 0, 0);
    set_mem(1'b0, 0, 0);
    #3;
    chk_all_zero("reset");
    #4;
    RESET = 1'b1;

    // Burst, then asynchronous reset mid-cycle.
    for (int i = 0; i < 4; i++) begin
      set_exe(1'b1, 20 + i, 200 + i);
      step();
    end
    #1;
    RESET = 1'b0;
    #1;
    chk_all_zero("async_reset");
    RESET = 1'b1;
    exe_valid = 1'b1;
    exe_map = 6'd5;
    exe_val = 32'hDEADBEEF;
    step();
    set_exe(1'b0, 0, 0);
    chk("first_after_reset", 80'({cdb_flag, cdb_map, cdb_val, cdb_src}),
        80'({1'b1, 6'd5, 32'hDEADBEEF, 1'b0}));

    // Same-cycle pushes from both sources.
    set_exe(1'b1, 1, 11);
    set_mem(1'b1, 2, 12);
    step();
    set_exe(1'b0, 0, 0);
    set_mem(1'b0, 0, 0);
    chk("same_cycle_exe", 80'({cdb_flag, cdb_map, cdb_src}), 80'({1'b1, 6'd1, 1'b0}));
    step();
    chk("same_cycle_mem", 80'({cdb_flag, cdb_map, cdb_src}), 80'({1'b1, 6'd2, 1'b1}));
    step();
    chk("same_cycle_idle", 80'(cdb_flag), 80'(0));

    // Starvation: EXE every cycle, one MEM push at cycle 0 wins after MAX_WAIT losses.
    for (int i = 0; i < 8; i++) begin
      set_exe(1'b1, 10 + i, 300 + i);
      set_mem(i == 0, 7, 400);
      step();
      if (i == 3) chk("starve_mem_wins", 80'({cdb_map, cdb_src}), 80'({6'd7, 1'b1}));
      else chk("starve_exe_order", 80'({cdb_map, cdb_src}),
               80'({6'(i < 3 ? 10 + i : 9 + i), 1'b0}));
    end
    set_exe(1'b0, 0, 0);
    set_mem(1'b0, 0, 0);
    for (int i = 0; i < 3; i++) step();

    // MEM overfill under continuous EXE traffic.
    for (int i = 0; i < 6; i++) begin
      set_exe(1'b1, 30 + i, 500 + i);
      set_mem(1'b1, 40 + i, 100 + i);
      step();
    end
    set_exe(1'b0, 0, 0);
    set_mem(1'b0, 0, 0);
    chk("fill_mem_count", 80'({mem_full, mem_count}), 80'({1'b1, 3'd4}));
    chk("fill_overflow", 80'(overflow), 80'(1));
    for (int i = 0; i < 8; i++) step();
    chk("fill_drained", 80'({mem_count, exe_count, cdb_flag}), 80'(0));
    chk("fill_overflow_sticky", 80'(overflow), 80'(1));

    // Build both FIFOs to 3 entries, then flush with fresh inputs.
    for (int i = 0; i < 12; i++) begin
      set_exe(1'b1, 50 + i, 600 + i);
      set_mem(1'b1, i, 700 + i);
      step();
    end
    chk("pre_flush_counts", 80'({exe_count, mem_count}), 80'({3'd3, 3'd3}));
    flush = 1'b1;
    set_exe(1'b1, 63, 999);
    set_mem(1'b1, 62, 998);
    step();
    flush = 1'b0;
    set_exe(1'b0, 0, 0);
    set_mem(1'b0, 0, 0);
    chk("flush_state", 80'({exe_count, mem_count, cdb_flag}), 80'(0));
    chk("flush_keeps_overflow", 80'(overflow), 80'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_discard", 80'(cdb_flag), 80'(0));
    end

    // Ten back-to-back MEM-only results.
    for (int i = 1; i <= 10; i++) begin
      set_mem(1'b1, i, i);
      step();
      chk("mem_seq", 80'({cdb_flag, cdb_src, cdb_instr_num}), 80'({1'b1, 1'b1, 32'(i)}));
    end
    set_mem(1'b0, 0, 0);
    step();
    chk("mem_seq_end", 80'({mem_count, cdb_flag}), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
